// File: rtl/mem_bus_pkg.sv
// Shared types for the memory arbiter slice: requester ownership, address
// regions, and the address decoder used at grant time.
package mem_bus_pkg;

    localparam logic [31:0] CON_ADDR_DEFAULT = 32'h1000_0000;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IFETCH,
        OWN_DATA
    } owner_t;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_CON,
        REG_BAD
    } region_t;

    // RAM wins if a tiny CON_ADDR ever falls inside the RAM window.
    function automatic region_t decodeRegion(input logic [31:0] addr,
                                             input logic [31:0] depth,
                                             input logic [31:0] conAddr);
        logic [33:0] ramLimit;
        region_t     region;
        ramLimit = {2'b00, depth} << 2;
        if ({2'b00, addr} < ramLimit) begin
            region = REG_RAM;
        end else if (addr == conAddr) begin
            region = REG_CON;
        end else begin
            region = REG_BAD;
        end
        return region;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Fixed-priority grant between fetch and data with a starvation counter that
// forces a fetch grant after MAX_DATA_RUN data grants while fetch waits.
module mem_arb_grant #(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_iReq,
    input  logic i_dReq,
    output logic o_iGnt,
    output logic o_dGnt
);

    localparam int CNT_W = $clog2(MAX_DATA_RUN + 1);

    logic [CNT_W-1:0] r_runCnt;
    logic             w_fetchDue;

    assign w_fetchDue = (r_runCnt == CNT_W'(MAX_DATA_RUN));

    always_comb begin
        o_iGnt = 1'b0;
        o_dGnt = 1'b0;
        if (!reset) begin
            if (i_iReq && i_dReq && w_fetchDue) begin
                o_iGnt = 1'b1;
            end else if (i_dReq) begin
                o_dGnt = 1'b1;
            end else if (i_iReq) begin
                o_iGnt = 1'b1;
            end
        end
    end

    // The count only measures how long fetch has been waiting, so it is
    // dropped as soon as fetch stops asking or is served.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_runCnt <= '0;
        end else if (!i_iReq || o_iGnt) begin
            r_runCnt <= '0;
        end else if (o_dGnt && !w_fetchDue) begin
            r_runCnt <= r_runCnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port, one-cycle-latency RAM between the fetch and data
// ports, and steers data writes to the console address onto a byte stream.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int          DEPTH        = 65536,
    parameter logic [31:0] CON_ADDR     = CON_ADDR_DEFAULT,
    parameter int          MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    output logic        bad_access
);

    logic        w_iGnt;
    logic        w_dGnt;
    logic        w_anyGnt;
    logic        w_ramGnt;
    logic [31:0] w_addr;
    region_t     w_decoded;
    region_t     w_region;
    owner_t      w_nextOwner;
    logic [31:0] w_respData;

    owner_t      r_owner;
    region_t     r_region;
    logic        r_conValid;
    logic [7:0]  r_conData;
    logic        r_bad;
    logic [31:0] r_lastAddr;

    mem_arb_grant #(
        .MAX_DATA_RUN(MAX_DATA_RUN)
    ) u_grant (
        .clk   (clk),
        .reset (reset),
        .i_iReq(i_req),
        .i_dReq(d_req),
        .o_iGnt(w_iGnt),
        .o_dGnt(w_dGnt)
    );

    assign i_gnt     = w_iGnt;
    assign d_gnt     = w_dGnt;
    assign w_anyGnt  = w_iGnt | w_dGnt;
    assign w_addr    = w_dGnt ? d_addr : i_addr;
    assign w_decoded = decodeRegion(w_addr, 32'(DEPTH), CON_ADDR);

    // The console is write-only for the data port; a fetch there is a fault.
    assign w_region  = (w_iGnt && w_decoded == REG_CON) ? REG_BAD : w_decoded;
    assign w_ramGnt  = w_anyGnt && (w_region == REG_RAM);
    assign mem_wdata = d_wdata;

    // mem_addr parks on the last RAM address so the RAM sees no spurious reads.
    always_comb begin
        mem_addr  = reset ? '0 : r_lastAddr;
        mem_write = '0;
        if (w_ramGnt) begin
            mem_addr = w_addr;
            if (w_dGnt) begin
                mem_write = d_wstrb;
            end
        end
    end

    always_comb begin
        w_nextOwner = OWN_NONE;
        if (w_dGnt) begin
            w_nextOwner = OWN_DATA;
        end else if (w_iGnt) begin
            w_nextOwner = OWN_IFETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= OWN_NONE;
            r_region   <= REG_RAM;
            r_conValid <= 1'b0;
            r_conData  <= '0;
            r_bad      <= 1'b0;
            r_lastAddr <= '0;
        end else begin
            r_owner    <= w_nextOwner;
            r_region   <= w_region;
            r_conValid <= w_dGnt && (w_region == REG_CON) && (d_wstrb != 4'b0000);
            r_bad      <= w_anyGnt && (w_region == REG_BAD);
            if (w_dGnt && (w_region == REG_CON) && (d_wstrb != 4'b0000)) begin
                r_conData <= d_wdata[7:0];
            end
            if (w_ramGnt) begin
                r_lastAddr <= w_addr;
            end
        end
    end

    // Outputs are masked while reset is high so a response already latched
    // before reset was raised is never delivered.
    assign w_respData = (r_region == REG_RAM) ? mem_rdata : '0;
    assign i_rvalid   = !reset && (r_owner == OWN_IFETCH);
    assign d_rvalid   = !reset && (r_owner == OWN_DATA);
    assign i_rdata    = i_rvalid ? w_respData : '0;
    assign d_rdata    = d_rvalid ? w_respData : '0;
    assign con_valid  = !reset && r_conValid;
    assign con_data   = con_valid ? r_conData : '0;
    assign bad_access = !reset && r_bad;

endmodule
